// File: rtl/uart_rx.sv
//==============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. Oversamples the serial line at 16 s_tick strobes
//            per bit and recovers LSB-first frames of DBIT data bits. An
//            optional even-parity bit is enabled by defining the macro
//            UART_RX_PARITY_EN.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous, active-low reset
//            rx           - serial line (asynchronous, idles high)
//            s_tick       - 16x baud oversampling strobe, one clk wide
//            dout         - last received byte, right-aligned, upper bits 0
//            rx_done_tick - one-clk pulse when a frame completes
//            frame_err    - stop bit of the last frame sampled low
//            parity_err   - parity mismatch on last frame (macro only)
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  localparam logic [2:0] N_LAST      = 3'(DBIT - 1);
  localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);

  state_t            state_q, state_d;
  logic [4:0]        s_q, s_d;          // wide enough for a 2-stop-bit count
  logic [2:0]        n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [7:0]        dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
  logic              perr_pend_q, perr_pend_d;  // parity result held until stop
`endif

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q      <= perr_d;
      perr_pend_q <= perr_pend_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    ferr_d      = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d      = perr_q;
    perr_pend_d = perr_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        // Re-check the line in the middle of the start bit to reject glitches.
        if (s_tick) begin
          if (s_q == 5'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            // LSB arrives first, so shifting right leaves it in b[0] at the end.
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            // Even parity: data ones plus parity bit must be an even count.
            perr_pend_d = (^b_q) ^ rx_s_q;
            s_d         = '0;
            state_d     = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = 8'(b_q);
            ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = perr_pend_q;
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx (DBIT=8, SB_TICK=16).
//            Parity scenarios are included when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       rx     = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  int tick_div = 4;
  int tick_cnt = 0;

  int   done_cnt  = 0;
  int   dbl_cnt   = 0;
  logic prev_done = 1'b0;
  logic [7:0] cap_dout[$];
  logic       cap_ferr[$];
`ifdef UART_RX_PARITY_EN
  logic       cap_perr[$];
`endif

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Baud strobe: one pulse every tick_div clocks, updated away from posedge.
  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) tick_cnt = 0;
    else tick_cnt = tick_cnt + 1;
    s_tick = (tick_cnt == tick_div - 1);
  end

  // Record every completed frame and any back-to-back done pulses.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      done_cnt = done_cnt + 1;
      cap_dout.push_back(dout);
      cap_ferr.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
      cap_perr.push_back(parity_err);
`endif
      if (prev_done === 1'b1) dbl_cnt = dbl_cnt + 1;
    end
    prev_done = rx_done_tick;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_caps();
    cap_dout.delete();
    cap_ferr.delete();
`ifdef UART_RX_PARITY_EN
    cap_perr.delete();
`endif
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  // Stop level held 10 ticks (covers the mid-bit sample), then line idles.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_ticks(16);
`else
    if (par === 1'bz) rx = 1'b1;
`endif
    rx = stop;
    wait_ticks(10);
    rx = 1'b1;
    wait_ticks(6);
  endtask

  function automatic logic [7:0] cap_d(input int idx);
    if (cap_dout.size() > idx) return cap_dout[idx];
    return 8'hxx;
  endfunction

  function automatic logic cap_f(input int idx);
    if (cap_ferr.size() > idx) return cap_ferr[idx];
    return 1'bx;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (dout !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_dout: got %h expected %h", dout, 8'h00);
    end
    vectors++;
    if (rx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", rx_done_tick);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
`ifdef UART_RX_PARITY_EN
    vectors++;
    if (parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_parity_err: got %b expected 0", parity_err);
    end
`endif
    reset = 1'b1;
    wait_ticks(20);
  endtask

  task automatic test_clean_frame();
    int base;
    clear_caps();
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(4);
    vectors++;
    if (done_cnt - base !== 1) begin
      miscompares++;
      $display("FAIL clean_done_count: got %0d expected 1", done_cnt - base);
    end
    vectors++;
    if (cap_d(0) !== 8'hA5) begin
      miscompares++;
      $display("FAIL clean_dout: got %h expected a5", cap_d(0));
    end
    vectors++;
    if (cap_f(0) !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_frame_err: got %b/%b expected 0", cap_f(0), frame_err);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = done_cnt;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    vectors++;
    if (done_cnt - base !== 0) begin
      miscompares++;
      $display("FAIL glitch_done_count: got %0d expected 0", done_cnt - base);
    end
    vectors++;
    if (dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL glitch_dout: got %h expected a5", dout);
    end
  endtask

  task automatic test_frame_error();
    int base;
    clear_caps();
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(4);
    vectors++;
    if (cap_d(0) !== 8'h3C) begin
      miscompares++;
      $display("FAIL ferr_dout: got %h expected 3c", cap_d(0));
    end
    vectors++;
    if (cap_f(0) !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_flag: got %b expected 1", cap_f(0));
    end
    wait_ticks(20);
    vectors++;
    if (frame_err !== 1'b1 || done_cnt - base !== 1) begin
      miscompares++;
      $display("FAIL ferr_held: got flag %b count %0d expected 1 and 1", frame_err, done_cnt - base);
    end
    send_frame(8'h55, 1'b0, 1'b1);
    wait_ticks(4);
    vectors++;
    if (cap_d(1) !== 8'h55 || cap_f(1) !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_recover: got dout %h flag %b expected 55 and 0", cap_d(1), cap_f(1));
    end
  endtask

  task automatic test_back_to_back();
    int base;
    clear_caps();
    base = done_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_ticks(4);
    vectors++;
    if (done_cnt - base !== 2) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - base);
    end
    vectors++;
    if (cap_d(0) !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_first: got %h expected 00", cap_d(0));
    end
    vectors++;
    if (cap_d(1) !== 8'hFF) begin
      miscompares++;
      $display("FAIL b2b_second: got %h expected ff", cap_d(1));
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] aborted;
    aborted = 8'h81;
    clear_caps();
    base = done_cnt;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = aborted[i];
      wait_ticks(16);
    end
    rx = aborted[3];
    wait_ticks(8);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dout !== 8'h00 || rx_done_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got dout %h done %b expected 00 and 0", dout, rx_done_tick);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ticks(30);
    send_frame(8'h42, 1'b0, 1'b1);
    wait_ticks(4);
    vectors++;
    if (done_cnt - base !== 1) begin
      miscompares++;
      $display("FAIL midreset_done_count: got %0d expected 1", done_cnt - base);
    end
    vectors++;
    if (cap_d(0) !== 8'h42 || dout !== 8'h42) begin
      miscompares++;
      $display("FAIL midreset_dout: got %h expected 42", cap_d(0));
    end
  endtask

  task automatic test_continuous_tick();
    int base;
    tick_div = 1;
    wait_ticks(20);
    clear_caps();
    base = done_cnt;
    send_frame(8'h96, 1'b1, 1'b1);
    wait_ticks(20);
    vectors++;
    if (done_cnt - base !== 1 || cap_d(0) !== 8'h96) begin
      miscompares++;
      $display("FAIL cont_tick: got count %0d dout %h expected 1 and 96", done_cnt - base, cap_d(0));
    end
    tick_div = 4;
    wait_ticks(20);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_caps();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_ticks(4);
    vectors++;
    if (cap_perr.size() < 1 || cap_perr[0] !== 1'b0 || cap_d(0) !== 8'h07) begin
      miscompares++;
      $display("FAIL parity_good: got perr %b dout %h expected 0 and 07", parity_err, cap_d(0));
    end
    send_frame(8'h07, 1'b0, 1'b1);
    wait_ticks(4);
    vectors++;
    if (cap_perr.size() < 2 || cap_perr[1] !== 1'b1 || cap_d(1) !== 8'h07) begin
      miscompares++;
      $display("FAIL parity_bad: got perr %b dout %h expected 1 and 07", parity_err, cap_d(1));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_continuous_tick();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (dbl_cnt !== 0) begin
      miscompares++;
      $display("FAIL done_pulse_width: got %0d double pulses expected 0", dbl_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
